// File: rtl/pixel_merger_pkg.sv
// Shared definitions for the four-lane pixel merger.
package pixel_merger_pkg;

   localparam int LANES  = 4;
   localparam int LANE_W = 2;
   localparam int PIX_W  = 8;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

endpackage

// File: rtl/pixel_merger_lane.sv
// Per-lane synchronous FIFO. The head entry is readable combinationally.
// When the FIFO is full, a write is still accepted in a cycle that also pops.
module lane_fifo
   import pixel_merger_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             wr,
   input  logic             rd,
   input  logic [PIX_W-1:0] din,
   output logic [PIX_W-1:0] dout,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   logic [PIX_W-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW:0]      count_q, count_d;
   logic             do_wr, do_rd;

   assign full  = (count_q == (AW+1)'(DEPTH));
   assign empty = (count_q == '0);
   assign do_rd = rd && !empty;
   assign do_wr = wr && (!full || do_rd);
   assign dout  = mem_q[rd_ptr_q];

   // Pointer and occupancy update; flush empties the FIFO regardless of traffic.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_wr) wr_ptr_d = wr_ptr_q + AW'(1);
         if (do_rd) rd_ptr_d = rd_ptr_q + AW'(1);
         case ({do_wr, do_rd})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
         endcase
      end
   end

   // Pointer/occupancy registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage array; contents need no reset since occupancy gates every read.
   always_ff @(posedge clk) begin
      if (do_wr && !flush) mem_q[wr_ptr_q] <= din;
   end

endmodule

// File: rtl/pixel_merger.sv
// Re-serialises four lane streams into one raster-ordered valid/ready stream,
// tracking frame completion and per-lane overflow.
module pixel_merger
   import pixel_merger_pkg::*;
#(
   parameter int DEPTH     = 8,
   parameter int FRAME_PIX = 65536
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [PIX_W-1:0] in_pixel0,
   input  logic [PIX_W-1:0] in_pixel1,
   input  logic [PIX_W-1:0] in_pixel2,
   input  logic [PIX_W-1:0] in_pixel3,
   input  logic             in_valid0,
   input  logic             in_valid1,
   input  logic             in_valid2,
   input  logic             in_valid3,
   output logic [PIX_W-1:0] m_pixel,
   output logic             m_valid,
   input  logic             m_ready,
   output logic             m_last,
   output logic             frame_done,
   output logic             busy,
   output logic [LANES-1:0] ovf
);

   localparam int              CW       = $clog2(FRAME_PIX) + 1;
   localparam logic [CW-1:0]   LAST_IDX = CW'(FRAME_PIX - 1);

   state_t            state_q, state_d;
   logic [LANE_W-1:0] lane_ptr_q, lane_ptr_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [PIX_W-1:0]  m_pixel_q, m_pixel_d;
   logic              m_valid_q, m_valid_d;
   logic              m_last_q, m_last_d;
   logic              frame_done_q, frame_done_d;
   logic [LANES-1:0]  ovf_q, ovf_d;

   logic [LANES-1:0]  in_valid;
   logic [PIX_W-1:0]  in_pixel   [LANES];
   logic [PIX_W-1:0]  fifo_dout  [LANES];
   logic [LANES-1:0]  fifo_wr, fifo_rd, fifo_full, fifo_empty;
   logic              load, accept;

   assign in_valid    = {in_valid3, in_valid2, in_valid1, in_valid0};
   assign in_pixel[0] = in_pixel0;
   assign in_pixel[1] = in_pixel1;
   assign in_pixel[2] = in_pixel2;
   assign in_pixel[3] = in_pixel3;

   for (genvar k = 0; k < LANES; k++) begin : g_lane
      lane_fifo #(.DEPTH(DEPTH)) u_fifo (
         .clk   (clk),
         .rst   (rst),
         .flush (start),
         .wr    (fifo_wr[k]),
         .rd    (fifo_rd[k]),
         .din   (in_pixel[k]),
         .dout  (fifo_dout[k]),
         .full  (fifo_full[k]),
         .empty (fifo_empty[k])
      );
   end

   // Lane writes and the strict round-robin pop; no pops once the last pixel is held.
   always_comb begin
      accept  = m_valid_q && m_ready;
      load    = (state_q == RUN) && !start && !(m_valid_q && m_last_q) &&
                (!m_valid_q || m_ready) && !fifo_empty[lane_ptr_q];
      fifo_wr = '0;
      fifo_rd = '0;
      for (int k = 0; k < LANES; k++) begin
         fifo_wr[k] = (state_q == RUN) && !start && in_valid[k];
         fifo_rd[k] = load && (lane_ptr_q == LANE_W'(k));
      end
   end

   // Next-state, output register, counter and sticky overflow computation.
   always_comb begin
      state_d      = state_q;
      lane_ptr_d   = lane_ptr_q;
      cnt_d        = cnt_q;
      m_pixel_d    = m_pixel_q;
      m_valid_d    = m_valid_q;
      m_last_d     = m_last_q;
      frame_done_d = 1'b0;
      ovf_d        = ovf_q;
      if (start) begin
         state_d    = RUN;
         lane_ptr_d = '0;
         cnt_d      = '0;
         m_pixel_d  = '0;
         m_valid_d  = 1'b0;
         m_last_d   = 1'b0;
         ovf_d      = '0;
      end else begin
         if (load) begin
            m_pixel_d  = fifo_dout[lane_ptr_q];
            m_valid_d  = 1'b1;
            m_last_d   = (cnt_q == LAST_IDX);
            lane_ptr_d = lane_ptr_q + LANE_W'(1);
            cnt_d      = cnt_q + CW'(1);
         end else if (accept) begin
            m_valid_d = 1'b0;
            m_last_d  = 1'b0;
         end
         if ((state_q == RUN) && accept && m_last_q) begin
            state_d      = IDLE;
            frame_done_d = 1'b1;
         end
         for (int k = 0; k < LANES; k++) begin
            if (fifo_wr[k] && fifo_full[k] && !fifo_rd[k]) ovf_d[k] = 1'b1;
         end
      end
   end

   // State and output registers; reset wins over a coincident start.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         lane_ptr_q   <= '0;
         cnt_q        <= '0;
         m_pixel_q    <= '0;
         m_valid_q    <= 1'b0;
         m_last_q     <= 1'b0;
         frame_done_q <= 1'b0;
         ovf_q        <= '0;
      end else begin
         state_q      <= state_d;
         lane_ptr_q   <= lane_ptr_d;
         cnt_q        <= cnt_d;
         m_pixel_q    <= m_pixel_d;
         m_valid_q    <= m_valid_d;
         m_last_q     <= m_last_d;
         frame_done_q <= frame_done_d;
         ovf_q        <= ovf_d;
      end
   end

   assign m_pixel    = m_pixel_q;
   assign m_valid    = m_valid_q;
   assign m_last     = m_last_q;
   assign frame_done = frame_done_q;
   assign busy       = (state_q == RUN);
   assign ovf        = ovf_q;

endmodule

// File: tb/tb_pixel_merger.sv
// Directed bench for pixel_merger: a large-frame instance and an 8-pixel-frame
// instance share the same stimulus.
module tb_pixel_merger;

   logic       clk = 1'b0;
   logic       rst, start, m_ready;
   logic [7:0] in_pixel0, in_pixel1, in_pixel2, in_pixel3;
   logic       in_valid0, in_valid1, in_valid2, in_valid3;

   logic [7:0] m_pixel, m_pixel_s;
   logic       m_valid, m_valid_s, m_last, m_last_s;
   logic       frame_done, frame_done_s, busy, busy_s;
   logic [3:0] ovf, ovf_s;

   int testsRun = 0;
   int testsFailed = 0;

   pixel_merger #(.DEPTH(8), .FRAME_PIX(65536)) dut (
      .clk(clk), .rst(rst), .start(start),
      .in_pixel0(in_pixel0), .in_pixel1(in_pixel1), .in_pixel2(in_pixel2), .in_pixel3(in_pixel3),
      .in_valid0(in_valid0), .in_valid1(in_valid1), .in_valid2(in_valid2), .in_valid3(in_valid3),
      .m_pixel(m_pixel), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last),
      .frame_done(frame_done), .busy(busy), .ovf(ovf)
   );

   pixel_merger #(.DEPTH(8), .FRAME_PIX(8)) dut8 (
      .clk(clk), .rst(rst), .start(start),
      .in_pixel0(in_pixel0), .in_pixel1(in_pixel1), .in_pixel2(in_pixel2), .in_pixel3(in_pixel3),
      .in_valid0(in_valid0), .in_valid1(in_valid1), .in_valid2(in_valid2), .in_valid3(in_valid3),
      .m_pixel(m_pixel_s), .m_valid(m_valid_s), .m_ready(m_ready), .m_last(m_last_s),
      .frame_done(frame_done_s), .busy(busy_s), .ovf(ovf_s)
   );

   // Free-running clock.
   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]  vld;
      logic [31:0] pix;
      logic        rdy;
      logic        ev;
      logic [7:0]  epix;
      logic        ev8;
      logic        elast8;
      logic        edone8;
      logic        ebusy8;
   } vec_t;

   vec_t tbl [17];

   // Drive one cycle of inputs, then sample 1 time unit after the edge.
   task automatic applyStimulus(input logic [3:0] vld, input logic [31:0] pix,
                                input logic rdy, input logic st);
      {in_valid3, in_valid2, in_valid1, in_valid0} = vld;
      {in_pixel3, in_pixel2, in_pixel1, in_pixel0} = pix;
      m_ready = rdy;
      start   = st;
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      testsRun++;
      if (act !== exp) begin
         testsFailed++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Global watchdog so the run always ends.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation exceeded its time limit");
      $fatal(1, "[TB] timeout");
   end

   // Main directed sequence.
   initial begin
      logic [7:0] expq [$];
      logic [7:0] got  [$];

      // Stimulus table: two rounds for the 8-pixel frame, then a round after it ends.
      tbl[0]  = '{4'hF, 32'h43322110, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1};
      tbl[1]  = '{4'h0, 32'h0,        1'b1, 1'b1, 8'h10, 1'b1, 1'b0, 1'b0, 1'b1};
      tbl[2]  = '{4'h0, 32'h0,        1'b1, 1'b1, 8'h21, 1'b1, 1'b0, 1'b0, 1'b1};
      tbl[3]  = '{4'h0, 32'h0,        1'b1, 1'b1, 8'h32, 1'b1, 1'b0, 1'b0, 1'b1};
      tbl[4]  = '{4'h0, 32'h0,        1'b1, 1'b1, 8'h43, 1'b1, 1'b0, 1'b0, 1'b1};
      tbl[5]  = '{4'h3, 32'h00006655, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1};
      tbl[6]  = '{4'hC, 32'h88770000, 1'b1, 1'b1, 8'h55, 1'b1, 1'b0, 1'b0, 1'b1};
      tbl[7]  = '{4'h0, 32'h0,        1'b1, 1'b1, 8'h66, 1'b1, 1'b0, 1'b0, 1'b1};
      tbl[8]  = '{4'h0, 32'h0,        1'b1, 1'b1, 8'h77, 1'b1, 1'b0, 1'b0, 1'b1};
      tbl[9]  = '{4'h0, 32'h0,        1'b1, 1'b1, 8'h88, 1'b1, 1'b1, 1'b0, 1'b1};
      tbl[10] = '{4'h0, 32'h0,        1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0};
      tbl[11] = '{4'hF, 32'hCCBBAA99, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[12] = '{4'h0, 32'h0,        1'b1, 1'b1, 8'h99, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[13] = '{4'h0, 32'h0,        1'b1, 1'b1, 8'hAA, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[14] = '{4'h0, 32'h0,        1'b1, 1'b1, 8'hBB, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[15] = '{4'h0, 32'h0,        1'b1, 1'b1, 8'hCC, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[16] = '{4'h0, 32'h0,        1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0};

      // Reset values.
      rst = 1'b1;
      applyStimulus(4'h0, 32'h0, 1'b0, 1'b0);
      applyStimulus(4'h0, 32'h0, 1'b0, 1'b0);
      checkOutput("reset m_pixel", 32'(m_pixel), 32'h0);
      checkOutput("reset m_valid", 32'(m_valid), 32'h0);
      checkOutput("reset m_last", 32'(m_last), 32'h0);
      checkOutput("reset frame_done", 32'(frame_done), 32'h0);
      checkOutput("reset busy", 32'(busy), 32'h0);
      checkOutput("reset ovf", 32'(ovf), 32'h0);
      rst = 1'b0;
      applyStimulus(4'h0, 32'h0, 1'b0, 1'b0);
      checkOutput("idle busy", 32'(busy), 32'h0);

      // Table-driven run: latency, throughput, m_last and frame_done on the short frame.
      applyStimulus(4'h0, 32'h0, 1'b1, 1'b1);
      checkOutput("start busy", 32'(busy), 32'h1);
      for (int i = 0; i < 17; i++) begin
         applyStimulus(tbl[i].vld, tbl[i].pix, tbl[i].rdy, 1'b0);
         checkOutput($sformatf("row%0d m_valid", i), 32'(m_valid), 32'(tbl[i].ev));
         if (tbl[i].ev) checkOutput($sformatf("row%0d m_pixel", i), 32'(m_pixel), 32'(tbl[i].epix));
         checkOutput($sformatf("row%0d m_last", i), 32'(m_last), 32'h0);
         checkOutput($sformatf("row%0d m_valid8", i), 32'(m_valid_s), 32'(tbl[i].ev8));
         if (tbl[i].ev8) checkOutput($sformatf("row%0d m_pixel8", i), 32'(m_pixel_s), 32'(tbl[i].epix));
         checkOutput($sformatf("row%0d m_last8", i), 32'(m_last_s), 32'(tbl[i].elast8));
         checkOutput($sformatf("row%0d frame_done8", i), 32'(frame_done_s), 32'(tbl[i].edone8));
         checkOutput($sformatf("row%0d busy8", i), 32'(busy_s), 32'(tbl[i].ebusy8));
      end

      // Overflow on lane 2, then drain in strict lane order.
      applyStimulus(4'h0, 32'h0, 1'b0, 1'b1);
      for (int i = 0; i < 9; i++) applyStimulus(4'h4, {8'h00, 8'(8'hA0 + i), 16'h0}, 1'b0, 1'b0);
      checkOutput("ovf lane2 only", 32'(ovf), 32'h4);
      checkOutput("ovf m_valid", 32'(m_valid), 32'h0);
      for (int i = 0; i < 8; i++) begin
         expq.push_back(8'(8'h50 + i));
         expq.push_back(8'(8'h10 + i));
         expq.push_back(8'(8'hA0 + i));
         expq.push_back(8'(8'h30 + i));
      end
      for (int c = 0; c < 100 && got.size() < 32; c++) begin
         if (c < 8) applyStimulus(4'hB, {8'(8'h30 + c), 8'h00, 8'(8'h10 + c), 8'(8'h50 + c)}, 1'b1, 1'b0);
         else       applyStimulus(4'h0, 32'h0, 1'b1, 1'b0);
         if (m_valid) got.push_back(m_pixel);
      end
      checkOutput("ovf drain count", 32'(got.size()), 32'd32);
      for (int i = 0; i < got.size() && i < 32; i++)
         checkOutput($sformatf("ovf drain px%0d", i), 32'(got[i]), 32'(expq[i]));
      checkOutput("ovf sticky", 32'(ovf), 32'h4);

      // Lane 1 starves: stream stalls after lane 0, resumes after lane 1 arrives.
      applyStimulus(4'h0, 32'h0, 1'b1, 1'b1);
      checkOutput("start clears ovf", 32'(ovf), 32'h0);
      applyStimulus(4'hD, 32'h04030001, 1'b1, 1'b0);
      checkOutput("starve write m_valid", 32'(m_valid), 32'h0);
      applyStimulus(4'h0, 32'h0, 1'b1, 1'b0);
      checkOutput("starve lane0 px", 32'(m_pixel), 32'h01);
      applyStimulus(4'h0, 32'h0, 1'b1, 1'b0);
      checkOutput("starve stall1", 32'(m_valid), 32'h0);
      applyStimulus(4'h0, 32'h0, 1'b1, 1'b0);
      checkOutput("starve stall2", 32'(m_valid), 32'h0);
      applyStimulus(4'h2, 32'h00000200, 1'b1, 1'b0);
      checkOutput("starve no bypass", 32'(m_valid), 32'h0);
      applyStimulus(4'h0, 32'h0, 1'b1, 1'b0);
      checkOutput("starve resume v", 32'(m_valid), 32'h1);
      checkOutput("starve resume px", 32'(m_pixel), 32'h02);
      applyStimulus(4'h0, 32'h0, 1'b1, 1'b0);
      checkOutput("starve lane2 px", 32'(m_pixel), 32'h03);
      applyStimulus(4'h0, 32'h0, 1'b1, 1'b0);
      checkOutput("starve lane3 px", 32'(m_pixel), 32'h04);
      applyStimulus(4'h0, 32'h0, 1'b1, 1'b0);
      checkOutput("starve end v", 32'(m_valid), 32'h0);

      // Backpressure hold for five cycles.
      applyStimulus(4'h0, 32'h0, 1'b0, 1'b1);
      applyStimulus(4'hF, 32'h5D5C5B5A, 1'b0, 1'b0);
      applyStimulus(4'h0, 32'h0, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) begin
         applyStimulus(4'h0, 32'h0, 1'b0, 1'b0);
         checkOutput($sformatf("hold%0d m_valid", i), 32'(m_valid), 32'h1);
         checkOutput($sformatf("hold%0d m_pixel", i), 32'(m_pixel), 32'h5A);
         checkOutput($sformatf("hold%0d m_last", i), 32'(m_last), 32'h0);
      end
      applyStimulus(4'h0, 32'h0, 1'b1, 1'b0);
      checkOutput("hold release px", 32'(m_pixel), 32'h5B);

      // start mid-frame flushes buffered data and restarts the counter.
      applyStimulus(4'h0, 32'h0, 1'b0, 1'b1);
      checkOutput("restart m_valid", 32'(m_valid), 32'h0);
      checkOutput("restart busy", 32'(busy), 32'h1);
      applyStimulus(4'h0, 32'h0, 1'b1, 1'b0);
      checkOutput("flushed1 m_valid", 32'(m_valid), 32'h0);
      applyStimulus(4'h0, 32'h0, 1'b1, 1'b0);
      checkOutput("flushed2 m_valid", 32'(m_valid), 32'h0);
      applyStimulus(4'hF, 32'hE3E2E1E0, 1'b1, 1'b0);
      for (int i = 0; i < 8; i++) begin
         if (i == 0) applyStimulus(4'hF, 32'hE7E6E5E4, 1'b1, 1'b0);
         else        applyStimulus(4'h0, 32'h0, 1'b1, 1'b0);
         checkOutput($sformatf("refill px%0d", i), 32'(m_pixel_s), 32'(8'hE0 + i));
         checkOutput($sformatf("refill last8 %0d", i), 32'(m_last_s), 32'(i == 7));
         checkOutput($sformatf("refill last %0d", i), 32'(m_last), 32'h0);
      end

      // rst and start together: reset wins.
      rst = 1'b1;
      applyStimulus(4'h0, 32'h0, 1'b1, 1'b1);
      checkOutput("rst+start busy", 32'(busy), 32'h0);
      checkOutput("rst+start busy8", 32'(busy_s), 32'h0);
      checkOutput("rst+start m_valid", 32'(m_valid), 32'h0);
      checkOutput("rst+start frame_done8", 32'(frame_done_s), 32'h0);
      rst = 1'b0;
      applyStimulus(4'hF, 32'h01010101, 1'b1, 1'b0);
      checkOutput("after rst busy", 32'(busy), 32'h0);
      applyStimulus(4'h0, 32'h0, 1'b1, 1'b0);
      checkOutput("after rst m_valid", 32'(m_valid), 32'h0);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
